bundle_ctrl_unit: RTL and testbench

//  Registered decode/control unit for the NUM_SLOTS-wide issue pipeline: one bundle = NUM_SLOTS x 16-bit slots in one IR word.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/slot_decoder.sv | 68 ++++++
 rtl/bundle_ctrl_unit.sv | 128 ++++++++++++
 tb/tb_bundle_ctrl_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/func constants, PC source and cause codes, FSM states, per-slot control bundle
package ctrl_pkg;

  localparam logic [4:0] OP_ALU    = 5'b01000;
  localparam logic [4:0] OP_IMM    = 5'b00101;
  localparam logic [4:0] OP_LOAD   = 5'b01010;
  localparam logic [4:0] OP_STORE  = 5'b01011;
  localparam logic [4:0] OP_JUMP   = 5'b11110;
  localparam logic [4:0] OP_BRANCH = 5'b11011;

  localparam logic [4:0] FN_ADD = 5'b00100;
  localparam logic [4:0] FN_SUB = 5'b01011;
  localparam logic [4:0] FN_AND = 5'b01100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_IMM = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_EXC    = 2'b11;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_OVF     = 2'b10;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_EXC   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  // flag_we bit order is {v, c, n, z}
  typedef struct packed {
    logic       reg_write;
    logic [3:0] flag_we;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } slot_ctrl_t;

endpackage

// File: rtl/slot_decoder.sv
// rtl/slot_decoder.sv - combinational decode of one 16-bit slot; even slots ALU, odd slots memory/flow
import ctrl_pkg::*;

module slot_decoder #(
  parameter bit IS_MEM_SLOT = 1'b0
) (
  input  logic [15:0] slot,
  output slot_ctrl_t  ctrl
);

  logic [4:0] opcode;
  logic [4:0] func;

  assign opcode = slot[4:0];
  assign func   = slot[9:5];

  // Anything that is not the all-zero NOP and not a listed encoding is illegal
  always_comb begin
    ctrl = '0;
    if (slot != 16'h0000) begin
      ctrl.illegal = 1'b1;
      if (!IS_MEM_SLOT) begin
        if (opcode == OP_ALU && func == FN_ADD) begin
          ctrl = '0;
          ctrl.reg_write = 1'b1;
          ctrl.flag_we   = 4'b1111;
          ctrl.alu_op    = ALU_ADD;
          ctrl.alu_src_a = 1'b1;
        end else if (opcode == OP_ALU && func == FN_SUB) begin
          ctrl = '0;
          ctrl.reg_write = 1'b1;
          ctrl.flag_we   = 4'b0111;
          ctrl.alu_op    = ALU_SUB;
          ctrl.alu_src_a = 1'b1;
        end else if (opcode == OP_ALU && func == FN_AND) begin
          ctrl = '0;
          ctrl.reg_write = 1'b1;
          ctrl.flag_we   = 4'b0011;
          ctrl.alu_op    = ALU_AND;
          ctrl.alu_src_a = 1'b1;
        end else if (opcode == OP_IMM) begin
          ctrl = '0;
          ctrl.reg_write = 1'b1;
          ctrl.flag_we   = 4'b1111;
          ctrl.alu_op    = ALU_IMM;
          ctrl.alu_src_b = 1'b1;
        end
      end else begin
        if (opcode == OP_LOAD) begin
          ctrl = '0;
          ctrl.reg_write = 1'b1;
          ctrl.flag_we   = 4'b0011;
          ctrl.mem_read  = 1'b1;
        end else if (opcode == OP_STORE) begin
          ctrl = '0;
          ctrl.mem_write = 1'b1;
        end else if (opcode == OP_JUMP) begin
          ctrl = '0;
          ctrl.jump = 1'b1;
        end else if (opcode == OP_BRANCH) begin
          ctrl = '0;
          ctrl.branch = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bundle_ctrl_unit.sv
// rtl/bundle_ctrl_unit.sv - registered bundle decode, PC source resolution and exception/flush sequencing
import ctrl_pkg::*;

module bundle_ctrl_unit #(
  parameter int NUM_SLOTS    = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CAUSE_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [16*NUM_SLOTS-1:0] ir,
  input  logic                    ir_valid,
  input  logic                    stall,
  input  logic                    n_flag,
  input  logic                    o_flag,
  output logic                    ctrl_valid,
  output logic [NUM_SLOTS-1:0]    reg_write,
  output logic [4*NUM_SLOTS-1:0]  flag_we,
  output logic [2*NUM_SLOTS-1:0]  alu_op,
  output logic [NUM_SLOTS-1:0]    alu_src_a,
  output logic [NUM_SLOTS-1:0]    alu_src_b,
  output logic [NUM_SLOTS-1:0]    mem_read,
  output logic [NUM_SLOTS-1:0]    mem_write,
  output logic [NUM_SLOTS-1:0]    branch,
  output logic [1:0]              pc_src,
  output logic                    if_flush,
  output logic                    id_flush,
  output logic                    ex_flush,
  output logic                    epc_write,
  output logic                    cause_write,
  output logic [CAUSE_W-1:0]      cause
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  slot_ctrl_t sc [NUM_SLOTS];

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    slot_decoder #(.IS_MEM_SLOT(g % 2 == 1)) u_dec (
      .slot (ir[16*g +: 16]),
      .ctrl (sc[g])
    );
  end

  logic [NUM_SLOTS-1:0]   d_rw, d_sa, d_sb, d_mr, d_mw, d_br;
  logic [4*NUM_SLOTS-1:0] d_fw;
  logic [2*NUM_SLOTS-1:0] d_op;
  logic [1:0]             d_pc;
  logic                   any_illegal;
  logic [SLOT_W-1:0]      ill_idx;

  // Descending scans so the lowest-index slot is the last (winning) assignment
  always_comb begin
    d_rw = '0; d_sa = '0; d_sb = '0; d_mr = '0; d_mw = '0; d_br = '0;
    d_fw = '0; d_op = '0; d_pc = PC_SRC_SEQ;
    any_illegal = 1'b0;
    ill_idx = '0;
    if (ir_valid) begin
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
        d_rw[k]       = sc[k].reg_write;
        d_fw[4*k +: 4] = sc[k].flag_we;
        d_op[2*k +: 2] = sc[k].alu_op;
        d_sa[k]       = sc[k].alu_src_a;
        d_sb[k]       = sc[k].alu_src_b;
        d_mr[k]       = sc[k].mem_read;
        d_mw[k]       = sc[k].mem_write;
        d_br[k]       = sc[k].branch;
        if (sc[k].branch && n_flag) d_pc = PC_SRC_BRANCH;
        else if (sc[k].jump) d_pc = PC_SRC_JUMP;
        if (sc[k].illegal) begin
          any_illegal = 1'b1;
          ill_idx = SLOT_W'(k);
        end
      end
    end
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             run_edge, ovf, stall_eff;

  // The edge that ends the last drain cycle decodes like RUN, but with o_flag and stall masked
  assign run_edge  = (state == ST_RUN) || (state == ST_DRAIN && cnt == '0);
  assign ovf       = o_flag && (state == ST_RUN);
  assign stall_eff = stall && (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt <= '0;
      ctrl_valid <= 1'b0;
      reg_write <= '0; flag_we <= '0; alu_op <= '0; alu_src_a <= '0; alu_src_b <= '0;
      mem_read <= '0; mem_write <= '0; branch <= '0;
      pc_src <= PC_SRC_SEQ;
      if_flush <= 1'b0; id_flush <= 1'b0; ex_flush <= 1'b0;
      epc_write <= 1'b0; cause_write <= 1'b0;
      cause <= '0;
    end else if (state == ST_EXC) begin
      state <= ST_DRAIN;
      cnt <= CNT_W'(FLUSH_CYCLES - 1);
      pc_src <= PC_SRC_SEQ;
      if_flush <= 1'b1; id_flush <= 1'b0; ex_flush <= 1'b0;
      epc_write <= 1'b0; cause_write <= 1'b0;
    end else if (!run_edge) begin
      cnt <= cnt - 1'b1;
    end else if (ovf || any_illegal) begin
      state <= ST_EXC;
      ctrl_valid <= 1'b0;
      reg_write <= '0; flag_we <= '0; alu_op <= '0; alu_src_a <= '0; alu_src_b <= '0;
      mem_read <= '0; mem_write <= '0; branch <= '0;
      pc_src <= PC_SRC_EXC;
      if_flush <= 1'b1; id_flush <= 1'b1; ex_flush <= ovf;
      epc_write <= 1'b1; cause_write <= 1'b1;
      cause <= ovf ? {CAUSE_OVF, {(CAUSE_W-2){1'b0}}}
                   : {CAUSE_ILLEGAL, (CAUSE_W-2)'(ill_idx)};
    end else if (!stall_eff) begin
      state <= ST_RUN;
      ctrl_valid <= ir_valid;
      reg_write <= d_rw; flag_we <= d_fw; alu_op <= d_op; alu_src_a <= d_sa; alu_src_b <= d_sb;
      mem_read <= d_mr; mem_write <= d_mw; branch <= d_br;
      pc_src <= d_pc;
      if_flush <= 1'b0; id_flush <= 1'b0; ex_flush <= 1'b0;
      epc_write <= 1'b0; cause_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bundle_ctrl_unit.sv
// tb/tb_bundle_ctrl_unit.sv - directed vectors with expected outputs queued per cycle and checked by a monitor
module tb_bundle_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir = '0;
  logic        ir_valid = 1'b0;
  logic        stall = 1'b0;
  logic        n_flag = 1'b0;
  logic        o_flag = 1'b0;
  logic        ctrl_valid;
  logic [1:0]  reg_write, alu_src_a, alu_src_b, mem_read, mem_write, branch, pc_src;
  logic [7:0]  flag_we, cause;
  logic [3:0]  alu_op;
  logic        if_flush, id_flush, ex_flush, epc_write, cause_write;

  bundle_ctrl_unit #(.NUM_SLOTS(2), .FLUSH_CYCLES(2), .CAUSE_W(8)) dut (
    .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid), .stall(stall),
    .n_flag(n_flag), .o_flag(o_flag), .ctrl_valid(ctrl_valid), .reg_write(reg_write),
    .flag_we(flag_we), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .pc_src(pc_src),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
    .epc_write(epc_write), .cause_write(cause_write), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [39:0] v;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  logic  done = 1'b0;
  logic [39:0] act;

  assign act = {ctrl_valid, reg_write, flag_we, alu_op, alu_src_a, alu_src_b, mem_read,
                mem_write, branch, pc_src, if_flush, id_flush, ex_flush, epc_write,
                cause_write, cause};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] ex(input logic cv, input logic [1:0] rw, input logic [7:0] fw,
                                     input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] mr, input logic [1:0] mw, input logic [1:0] br,
                                     input logic [1:0] pc, input logic [2:0] fl, input logic ew,
                                     input logic cw, input logic [7:0] cs);
    return {cv, rw, fw, op, sa, sb, mr, mw, br, pc, fl, ew, cw, cs};
  endfunction

  task automatic step(input logic rst, input logic [31:0] b, input logic v, input logic s,
                      input logic n, input logic o, input string nm, input logic [39:0] e);
    item_t it;
    @(posedge clk);
    #2;
    reset = rst; ir = b; ir_valid = v; stall = s; n_flag = n; o_flag = o;
    it.cyc = cyc + 1;
    it.name = nm;
    it.v = e;
    q.push_back(it);
  endtask

  initial begin
    item_t it;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #5;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        it = q.pop_front();
        n_tests++;
        if (it.cyc != cyc || act !== it.v) begin
          n_fail++;
          $display("FAIL %s: got %h want %h (cycle %0d, due %0d)", it.name, act, it.v, cyc, it.cyc);
        end
      end
      if (done && q.size() == 0) break;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d expectations still pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [39:0] e_si;
    e_si = ex(1, 2'b01, 8'h0F, 4'h1, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0, 0, 8'h00);

    step(1, 32'h0, 0, 0, 0, 0, "reset", 40'h0);
    step(0, 32'h0000_0000, 1, 0, 0, 0, "nop_bundle",
         ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00));
    step(0, 32'h000A_0088, 1, 0, 0, 0, "load_add",
         ex(1, 2'b11, 8'h3F, 4'h0, 2'b01, 0, 2'b10, 0, 0, 2'b00, 0, 0, 0, 8'h00));
    step(0, 32'h001B_0000, 1, 0, 1, 0, "branch_taken",
         ex(1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0, 8'h00));
    step(0, 32'h001B_0000, 1, 0, 0, 0, "branch_not_taken",
         ex(1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 8'h00));
    step(0, 32'h001E_0168, 1, 0, 0, 0, "jump_sub",
         ex(1, 2'b01, 8'h07, 4'h3, 2'b01, 0, 0, 0, 0, 2'b10, 0, 0, 0, 8'h00));
    step(0, 32'h000B_0005, 1, 0, 0, 0, "store_imm", e_si);
    step(0, 32'h000A_0188, 1, 1, 0, 0, "stall_hold", e_si);
    step(0, 32'h000A_0188, 1, 0, 0, 0, "load_and",
         ex(1, 2'b11, 8'h33, 4'h2, 2'b01, 0, 2'b10, 0, 0, 2'b00, 0, 0, 0, 8'h00));
    step(0, 32'h0000_0003, 1, 0, 0, 0, "exc_illegal_slot0",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b110, 1, 1, 8'h40));
    step(0, 32'h0, 1, 0, 0, 0, "drain1",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b100, 0, 0, 8'h40));
    step(0, 32'h0, 1, 0, 0, 0, "drain2",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b100, 0, 0, 8'h40));
    step(0, 32'h000A_0088, 1, 0, 0, 0, "run_after_drain",
         ex(1, 2'b11, 8'h3F, 4'h0, 2'b01, 0, 2'b10, 0, 0, 2'b00, 0, 0, 0, 8'h40));
    step(0, 32'h0088_0000, 1, 0, 0, 0, "exc_illegal_slot1",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b110, 1, 1, 8'h41));
    step(0, 32'h0, 0, 0, 0, 0, "drain1_b",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b100, 0, 0, 8'h41));
    step(0, 32'h0, 0, 0, 0, 0, "drain2_b",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b100, 0, 0, 8'h41));
    step(0, 32'h0, 0, 0, 0, 0, "idle_after_drain",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 8'h41));
    step(0, 32'h0000_0003, 0, 0, 0, 0, "invalid_illegal_ignored",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 8'h41));
    step(0, 32'h0, 1, 1, 0, 1, "exc_ovf_over_stall",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b111, 1, 1, 8'h80));
    step(0, 32'h0, 1, 0, 0, 1, "ovf_in_exc_ignored",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b100, 0, 0, 8'h80));
    step(0, 32'h0, 1, 0, 0, 1, "ovf_in_drain_ignored",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b100, 0, 0, 8'h80));
    step(0, 32'h000A_0088, 1, 0, 0, 1, "drain_exit_masks_ovf",
         ex(1, 2'b11, 8'h3F, 4'h0, 2'b01, 0, 2'b10, 0, 0, 2'b00, 0, 0, 0, 8'h80));
    step(0, 32'h0000_0003, 1, 1, 0, 0, "illegal_overrides_stall",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b110, 1, 1, 8'h40));
    step(0, 32'h0, 1, 0, 0, 0, "drain1_c",
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b100, 0, 0, 8'h40));
    step(1, 32'h0, 1, 0, 0, 0, "reset_in_drain", 40'h0);
    step(0, 32'h000A_0088, 1, 0, 0, 0, "decode_after_reset",
         ex(1, 2'b11, 8'h3F, 4'h0, 2'b01, 0, 2'b10, 0, 0, 2'b00, 0, 0, 0, 8'h00));
    done = 1'b1;
  end

endmodule
